project_info_tx: RTL and testbench

PROJECT_INFO_TX -- requirements
Module: project_info_tx

---
 rtl/project_info_pkg.sv | 22 ++
 rtl/project_info_csum.sv | 26 ++
 rtl/project_info_tx.sv | 134 +++++++++++++
 tb/tb_project_info_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/project_info_pkg.sv
// Shared constants, FSM encoding and frame sizing for the
// project info byte streamer.
package project_info_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CSUM
  } state_t;

  // Header + hash + four version fields + checksum.
  function automatic int frame_bytes(
    input int hash_bits,
    input int field_bits
  );
    return 2 + hash_bits / 8 + 4 * (field_bits / 8);
  endfunction

endpackage

// File: rtl/project_info_csum.sv
// Running mod-256 sum of every byte handed to the sink
// ahead of the checksum byte.
module project_info_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else if (clr) begin
      sum_q <= 8'h00;
    end else if (add) begin
      sum_q <= sum_q + din;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/project_info_tx.sv
// Streams a header, snapshotted hash/version fields and a
// checksum out over a valid/ready byte interface.
module project_info_tx
  import project_info_pkg::*;
#(
  parameter int COMMIT_HASH_DEPTH = 32,
  parameter int DEPTH             = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [COMMIT_HASH_DEPTH-1:0] i_commit_hash,
  input  logic [DEPTH-1:0]             i_major,
  input  logic [DEPTH-1:0]             i_minor,
  input  logic [DEPTH-1:0]             i_patch,
  input  logic [DEPTH-1:0]             i_build,
  input  logic                         i_req,
  output logic                         o_busy,
  output logic [7:0]                   o_tdata,
  output logic                         o_tvalid,
  input  logic                         i_tready,
  output logic                         o_tlast,
  output logic                         o_done
);

  localparam int PAY_BYTES =
    frame_bytes(COMMIT_HASH_DEPTH, DEPTH) - 2;
  localparam int PAY_BITS = PAY_BYTES * 8;
  localparam int CNT_W =
    (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(PAY_BYTES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [PAY_BITS-1:0] snap_q;
  logic [7:0]          sum;
  logic                done_q;
  logic                hs;
  logic                accept;
  logic                last_pay;
  logic                csum_add;

  assign hs       = o_tvalid & i_tready;
  assign accept   = (state_q == IDLE) & i_req;
  assign last_pay = (cnt_q == LAST_IDX);
  assign csum_add = hs & ((state_q == HEADER) |
                          (state_q == PAYLOAD));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req) state_d = HEADER;
      HEADER:  if (hs) state_d = PAYLOAD;
      PAYLOAD: if (hs && last_pay) state_d = CSUM;
      CSUM:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_busy   = 1'b0;
    o_tdata  = 8'h00;
    unique case (state_q)
      IDLE: begin
        o_tdata = 8'h00;
      end
      HEADER: begin
        o_tvalid = 1'b1;
        o_busy   = 1'b1;
        o_tdata  = HEADER_BYTE;
      end
      PAYLOAD: begin
        o_tvalid = 1'b1;
        o_busy   = 1'b1;
        o_tdata  = snap_q[PAY_BITS-1 -: 8];
      end
      CSUM: begin
        o_tvalid = 1'b1;
        o_busy   = 1'b1;
        o_tlast  = 1'b1;
        o_tdata  = sum;
      end
      default: begin
        o_tdata = 8'h00;
      end
    endcase
  end

  // Snapshot is shifted so the next payload byte is always on top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      snap_q <= {i_commit_hash, i_major, i_minor,
                 i_patch, i_build};
    end else if (hs && state_q == PAYLOAD) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      snap_q <= {snap_q[PAY_BITS-9:0], 8'h00};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= hs & (state_q == CSUM);
    end
  end

  assign o_done = done_q;

  project_info_csum u_csum (
    .clk (i_clk),
    .rst (i_rst),
    .clr (accept),
    .add (csum_add),
    .din (o_tdata),
    .sum (sum)
  );

endmodule

// File: tb/tb_project_info_tx.sv
// Directed checks of the project info streamer: frame content,
// stalls, ignored requests, mid-frame reset and back-to-back frames.
module tb_project_info_tx;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_commit_hash;
  logic [7:0]  i_major;
  logic [7:0]  i_minor;
  logic [7:0]  i_patch;
  logic [7:0]  i_build;
  logic        i_req;
  logic        o_busy;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tlast;
  logic        o_done;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [10];

  always #5 clk = ~clk;

  project_info_tx #(
    .COMMIT_HASH_DEPTH (32),
    .DEPTH             (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_commit_hash (i_commit_hash),
    .i_major       (i_major),
    .i_minor       (i_minor),
    .i_patch       (i_patch),
    .i_build       (i_build),
    .i_req         (i_req),
    .o_busy        (o_busy),
    .o_tdata       (o_tdata),
    .o_tvalid      (o_tvalid),
    .i_tready      (i_tready),
    .o_tlast       (o_tlast),
    .o_done        (o_done)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_frame(
    input logic [31:0] h,
    input logic [7:0]  ma,
    input logic [7:0]  mi,
    input logic [7:0]  pa,
    input logic [7:0]  bu,
    input logic [7:0]  cs
  );
    i_commit_hash = h;
    i_major = ma;
    i_minor = mi;
    i_patch = pa;
    i_build = bu;
    exp_q[0] = 8'hA5;
    exp_q[1] = h[31:24];
    exp_q[2] = h[23:16];
    exp_q[3] = h[15:8];
    exp_q[4] = h[7:0];
    exp_q[5] = ma;
    exp_q[6] = mi;
    exp_q[7] = pa;
    exp_q[8] = bu;
    exp_q[9] = cs;
  endtask

  // Called at a negedge with the frame header already presented.
  task automatic recv_frame(
    input string tag,
    input int    nbytes,
    input bit    stall,
    input bit    hold,
    input int    req_at,
    input int    hash_at,
    input int    exp_cycles
  );
    int idx = 0;
    int cyc = 0;
    while (idx < nbytes && cyc < 60) begin
      check({tag, "_tvalid"}, 32'(o_tvalid), 32'd1);
      check({tag, "_tdata"}, 32'(o_tdata), 32'(exp_q[idx]));
      check({tag, "_tlast"}, 32'(o_tlast), 32'(idx == 9));
      check({tag, "_busy"}, 32'(o_busy), 32'd1);
      i_req = hold || (idx == req_at);
      if (idx == hash_at) i_commit_hash = 32'h12345678;
      i_tready = stall ? 1'(cyc % 2) : 1'b1;
      if (i_tready) idx++;
      @(negedge clk);
      cyc++;
    end
    i_req = hold;
    check({tag, "_bytes"}, 32'(idx), 32'(nbytes));
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    if (nbytes == 10) begin
      check({tag, "_done"}, 32'(o_done), 32'd1);
      check({tag, "_idle_tvalid"}, 32'(o_tvalid), 32'd0);
      check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    end
  endtask

  task automatic start_req();
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
  endtask

  initial begin
    bit seen;
    i_rst = 1'b1;
    i_req = 1'b0;
    i_tready = 1'b1;
    set_frame(32'hDEADBEEF, 8'd1, 8'd2, 8'd3, 8'd4, 8'hE7);
    repeat (2) @(negedge clk);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_tdata", 32'(o_tdata), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_tvalid", 32'(o_tvalid), 32'd0);

    start_req();
    recv_frame("s1", 10, 1'b0, 1'b0, -1, -1, 10);
    @(negedge clk);
    check("s1_done_drop", 32'(o_done), 32'd0);

    start_req();
    recv_frame("s2", 10, 1'b1, 1'b0, -1, -1, 20);
    i_tready = 1'b1;
    @(negedge clk);

    start_req();
    recv_frame("s3", 10, 1'b0, 1'b0, 3, 5, 10);
    repeat (3) begin
      @(negedge clk);
      check("s3_no_requeue", 32'(o_tvalid), 32'd0);
    end
    i_commit_hash = 32'hDEADBEEF;

    start_req();
    recv_frame("s4", 5, 1'b0, 1'b0, -1, -1, 5);
    check("s4_byte5", 32'(o_tdata), 32'h01);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("s4_abort_tvalid", 32'(o_tvalid), 32'd0);
    check("s4_abort_busy", 32'(o_busy), 32'd0);
    check("s4_abort_done", 32'(o_done), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_done || o_tvalid) seen = 1'b1;
    end
    check("s4_quiet", 32'(seen), 32'd0);
    start_req();
    recv_frame("s4b", 10, 1'b0, 1'b0, -1, -1, 10);
    @(negedge clk);

    i_req = 1'b1;
    @(negedge clk);
    recv_frame("s5a", 10, 1'b0, 1'b1, -1, -1, 10);
    @(negedge clk);
    recv_frame("s5b", 10, 1'b0, 1'b1, -1, -1, 10);
    i_req = 1'b0;
    @(negedge clk);
    check("s5_stop", 32'(o_tvalid), 32'd0);

    set_frame(32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h9D);
    start_req();
    recv_frame("s6", 10, 1'b0, 1'b0, -1, -1, 10);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

endmodule
